zuc256_ks_prefetch: RTL and testbench

//  Keystream prefetch responder between a keystream consumer (zuc256_ctr_ext-style init/next initiator) and the ZUC-256 core.

---
 rtl/zuc256_ks_prefetch.sv | 209 ++++++++++++++++++++
 tb/tb_zuc256_ks_prefetch.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zuc256_ks_prefetch.sv
// Keystream prefetch responder: keeps a DEPTH-word FIFO of ZUC-256 keystream
// topped up from the core and answers consumer init/next requests from it.
module zuc256_ks_prefetch #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         init,
  input  logic                         next,
  output logic [31:0]                  z,
  output logic                         ready,
  output logic                         core_init,
  output logic                         core_next,
  input  logic [31:0]                  core_z,
  input  logic                         core_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fill
);

  localparam int unsigned FW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned WW = 32;

  typedef enum logic [1:0] {
    C_OFF   = 2'd0,
    C_GUARD = 2'd1,
    C_WAIT  = 2'd2,
    C_RUN   = 2'd3
  } c_state_t;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_PEND = 1'b1
  } d_state_t;

  c_state_t        c_state;
  c_state_t        c_state_d;
  d_state_t        d_state;
  d_state_t        d_state_d;

  logic            drop;
  logic            drop_d;
  logic            init_pend;
  logic            init_pend_d;
  logic            core_init_d;
  logic            core_next_d;
  logic            ready_d;

  logic            flush;
  logic            session;
  logic            push;
  logic            pop;
  logic [FW-1:0]   fill_after;

  logic [WW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Shared request decode; init always wins over next and empties the FIFO.
  always_comb begin
    flush      = init;
    session    = (c_state != C_OFF);
    pop        = (d_state == D_PEND) && !flush && (fill != '0);
    fill_after = fill - FW'(pop);
  end

  // Core FSM next state: one core operation in flight at a time, never aborted.
  always_comb begin
    c_state_d   = c_state;
    drop_d      = drop;
    init_pend_d = init_pend;
    core_init_d = 1'b0;
    core_next_d = 1'b0;
    push        = 1'b0;
    case (c_state)
      C_OFF: begin
        if (init) begin
          core_init_d = 1'b1;
          c_state_d   = C_GUARD;
        end
      end
      C_GUARD: begin
        // core_ready may still be stale in the pulse cycle
        c_state_d = C_WAIT;
        if (init) begin
          drop_d      = 1'b1;
          init_pend_d = 1'b1;
        end
      end
      C_WAIT: begin
        if (core_ready) begin
          if (drop || init) begin
            // word belongs to a superseded session
            drop_d = 1'b0;
            if (init_pend || init) begin
              core_init_d = 1'b1;
              init_pend_d = 1'b0;
              c_state_d   = C_GUARD;
            end else begin
              c_state_d = C_RUN;
            end
          end else begin
            push      = 1'b1;
            c_state_d = C_RUN;
          end
        end else if (init) begin
          drop_d      = 1'b1;
          init_pend_d = 1'b1;
        end
      end
      C_RUN: begin
        if (init) begin
          core_init_d = 1'b1;
          c_state_d   = C_GUARD;
        end else if (fill_after < FW'(DEPTH)) begin
          core_next_d = 1'b1;
          c_state_d   = C_GUARD;
        end
      end
      default: begin
        c_state_d = C_OFF;
      end
    endcase
  end

  // Consumer FSM next state: one outstanding request, served from the FIFO head.
  always_comb begin
    d_state_d = d_state;
    ready_d   = ready;
    case (d_state)
      D_IDLE: begin
        if (init) begin
          ready_d   = 1'b0;
          d_state_d = D_PEND;
        end else if (next && session) begin
          ready_d   = 1'b0;
          d_state_d = D_PEND;
        end
      end
      D_PEND: begin
        if (pop) begin
          ready_d   = 1'b1;
          d_state_d = D_IDLE;
        end
      end
      default: begin
        d_state_d = D_IDLE;
      end
    endcase
  end

  // State, flag and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_state   <= C_OFF;
      d_state   <= D_IDLE;
      drop      <= 1'b0;
      init_pend <= 1'b0;
      core_init <= 1'b0;
      core_next <= 1'b0;
      ready     <= 1'b0;
    end else begin
      c_state   <= c_state_d;
      d_state   <= d_state_d;
      drop      <= drop_d;
      init_pend <= init_pend_d;
      core_init <= core_init_d;
      core_next <= core_next_d;
      ready     <= ready_d;
    end
  end

  // Keystream output word, loaded from the FIFO head on each pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z <= '0;
    end else if (pop) begin
      z <= mem[rd_ptr];
    end
  end

  // FIFO pointers and occupancy; a flush also swallows a coincident push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      fill <= fill + FW'(push) - FW'(pop);
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= core_z;
    end
  end

endmodule

// File: tb/tb_zuc256_ks_prefetch.sv
// Bench for zuc256_ks_prefetch: directed consumer traffic against a simple
// latency-programmable core model, with a transaction-level scoreboard.
module tb_zuc256_ks_prefetch;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned FW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          init;
  logic          next;
  logic [31:0]   z;
  logic          ready;
  logic          core_init;
  logic          core_next;
  logic [31:0]   core_z;
  logic          core_ready;
  logic [FW-1:0] fill;

  always #5 clk = ~clk;

  zuc256_ks_prefetch #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .next       (next),
    .z          (z),
    .ready      (ready),
    .core_init  (core_init),
    .core_next  (core_next),
    .core_z     (core_z),
    .core_ready (core_ready),
    .fill       (fill)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: busy for lat cycles after each pulse, word = 0xA000_0000 + op index.
  int lat = 3;
  int cnt = 0;
  int op_idx = 0;
  int cur_op = 0;
  int sess_base = 0;
  int sess_done = 0;
  int sess_pulses = 0;
  int n_init = 0;
  int n_next = 0;

  initial begin
    core_ready = 1'b1;
    core_z     = 32'h0;
  end

  always @(posedge clk) begin
    if (core_init || core_next) begin
      check("pulse_when_core_idle", 64'(core_ready), 64'd1);
      core_ready <= 1'b0;
      cnt        <= lat - 1;
      cur_op     <= op_idx;
      op_idx     <= op_idx + 1;
      if (core_init) begin
        n_init      <= n_init + 1;
        sess_base   <= op_idx;
        sess_done   <= 0;
        sess_pulses <= 1;
      end else begin
        n_next      <= n_next + 1;
        sess_pulses <= sess_pulses + 1;
      end
    end else if (!core_ready) begin
      if (cnt == 0) begin
        core_ready <= 1'b1;
        core_z     <= 32'hA000_0000 + 32'(cur_op);
        sess_done  <= sess_done + 1;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  // Consumer-side model state.
  bit          session_on  = 1'b0;
  bit          outstanding = 1'b0;
  bit          fast        = 1'b0;
  int          delivered   = 0;
  int          req_edge    = -10;
  int          rises       = 0;
  logic        ready_prev  = 1'b0;
  logic [31:0] z_prev      = 32'h0;

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (reset) begin
      ready_prev = 1'b0;
    end else begin
      check("fill_le_depth", 64'(fill <= FW'(DEPTH)), 64'd1);
      check("one_pulse_kind", 64'(core_init & core_next), 64'd0);
      if (cyc == req_edge)
        check("ready_low_after_req", 64'(ready), 64'd0);
      if (fast && cyc == req_edge + 1)
        check("ready_latency", 64'(ready), 64'd1);
      if (ready && !ready_prev) begin
        rises++;
        check("ready_solicited", 64'(outstanding), 64'd1);
        check("z_order", 64'(z), 64'(32'hA000_0000 + 32'(sess_base + delivered)));
        outstanding = 1'b0;
        delivered++;
      end else if (ready && ready_prev) begin
        check("z_stable", 64'(z), 64'(z_prev));
      end
      ready_prev = ready;
      z_prev     = z;
    end
  end

  // Drive a one-cycle request and record what the model expects of it.
  task automatic req(input bit i, input bit n);
    @(negedge clk); #1;
    init = i;
    next = n;
    if (i) begin
      session_on  = 1'b1;
      outstanding = 1'b1;
      delivered   = 0;
      fast        = 1'b0;
      req_edge    = cyc + 1;
    end else if (n && session_on && !outstanding) begin
      outstanding = 1'b1;
      fast        = (sess_done > delivered);
      req_edge    = cyc + 1;
    end
    @(negedge clk); #1;
    init = 1'b0;
    next = 1'b0;
  endtask

  task automatic wait_done(input int max, input string name);
    int k = 0;
    while (outstanding && k < max) begin
      @(negedge clk); #1;
      k++;
    end
    check({name, "_timeout"}, 64'(outstanding), 64'd0);
  endtask

  task automatic wait_fill(input int max);
    int k = 0;
    while (fill != FW'(DEPTH) && k < max) begin
      @(negedge clk); #1;
      k++;
    end
    check("fill_reaches_depth", 64'(fill), 64'(DEPTH));
  endtask

  int n0;
  int r0;
  int inflight;
  int k;

  initial begin
    init  = 1'b0;
    next  = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_z", 64'(z), 64'd0);
    check("rst_fill", 64'(fill), 64'd0);
    check("rst_core_init", 64'(core_init), 64'd0);
    check("rst_core_next", 64'(core_next), 64'd0);

    // next with no session is ignored
    n0 = n_init + n_next;
    req(1'b0, 1'b1);
    repeat (8) @(negedge clk);
    check("no_pulse_before_init", 64'(n_init + n_next), 64'(n0));
    check("no_ready_before_init", 64'(ready), 64'd0);

    // first init: one core_init, init word, then prefetch to full
    req(1'b1, 1'b0);
    wait_done(50, "init_word");
    check("init_word_literal", 64'(z), 64'h0000_0000_A000_0000);
    wait_fill(100);
    repeat (10) @(negedge clk);
    check("init_pulse_count", 64'(n_init), 64'd1);
    check("prefetch_next_count", 64'(n_next), 64'(DEPTH));
    check("fill_full_idle", 64'(fill), 64'(DEPTH));

    // eight spaced nexts deliver the following words in order
    for (int i = 0; i < 8; i++) begin
      req(1'b0, 1'b1);
      wait_done(200, "next_word");
      check("next_word_literal", 64'(z), 64'(32'hA000_0001 + 32'(i)));
      @(negedge clk);
    end

    // init while a core_next is in flight: in-flight word must be discarded
    k = 0;
    while (!core_next && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("inflight_next_seen", 64'(core_next), 64'd1);
    inflight = op_idx;
    n0 = n_init;
    req(1'b1, 1'b0);
    wait_done(100, "reinit_word");
    check("reinit_skips_inflight", 64'(z), 64'(32'hA000_0000 + 32'(inflight + 1)));
    check("reinit_one_core_init", 64'(n_init), 64'(n0 + 1));

    // init and next together behave as a single init
    repeat (5) @(negedge clk);
    n0 = n_init;
    r0 = rises;
    req(1'b1, 1'b1);
    wait_done(100, "init_next_word");
    repeat (10) @(negedge clk);
    check("init_next_one_core_init", 64'(n_init), 64'(n0 + 1));
    check("init_next_one_ready", 64'(rises), 64'(r0 + 1));

    // asynchronous reset while the FIFO is being refilled
    req(1'b0, 1'b1);
    wait_done(100, "pre_reset_word");
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("async_rst_ready", 64'(ready), 64'd0);
    check("async_rst_z", 64'(z), 64'd0);
    check("async_rst_fill", 64'(fill), 64'd0);
    check("async_rst_core_init", 64'(core_init), 64'd0);
    check("async_rst_core_next", 64'(core_next), 64'd0);
    session_on  = 1'b0;
    outstanding = 1'b0;
    fast        = 1'b0;
    req_edge    = -10;
    n0 = n_init + n_next;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("no_pulse_after_reset", 64'(n_init + n_next), 64'(n0));
    check("ready_low_after_reset", 64'(ready), 64'd0);

    // slow core, back-to-back nexts
    lat = 20;
    req(1'b1, 1'b0);
    wait_done(400, "slow_init_word");
    for (int i = 0; i < 6; i++) begin
      req(1'b0, 1'b1);
      wait_done(400, "slow_next_word");
    end
    wait_fill(600);
    repeat (30) @(negedge clk);
    check("pulses_eq_words", 64'(sess_pulses), 64'(delivered + int'(fill)));
    check("slow_fill_capped", 64'(fill), 64'(DEPTH));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
